sprite_attr_fetch: RTL and testbench
====================================

SPRITE_ATTR_FETCH -- requirements
Module: sprite_attr_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, shared-memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, shared-memory address width.
REQ-003 SHALL have parameter BASE_ADDR, default 'h1000, address of the sprite X word; Y at BASE_ADDR+1, frame at BASE_ADDR+2.
REQ-004 SHALL have parameter SPRITE_W, default 16, and SPRITE_H, default 16, sprite size in pixels (powers of two).
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 vblank_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-008 data_in  input  DATA_WIDTH  read data from the shared memory, valid one cycle after addr.
REQ-009 addr  output  ADDR_WIDTH  read address to the shared memory (read-only port, no write enable).
REQ-010 hcount, vcount  input  10 each  current pixel coordinates from the VGA timing generator.
REQ-011 sprite_x, sprite_y  output  DATA_WIDTH each  committed sprite position.
REQ-012 sprite_frame  output  2  committed animation frame (0 standing, 1 walk start, 2 walk mid, 3 walk end).
REQ-013 attr_updated  output  1  one-cycle pulse when new attributes are committed.
REQ-014 frame_err  output  1  one-cycle pulse when a fetched frame word is out of range.
REQ-015 sprite_hit  output  1  registered; pixel (hcount,vcount) lies inside the sprite box.
REQ-016 glyph_addr  output  10  registered glyph ROM address {frame[1:0], row[3:0], col[3:0]}.

Function
REQ-017 SHALL implement FSM states IDLE, RD_X, RD_Y, RD_M, CAP_M, COMMIT.
REQ-018 IDLE -> RD_X when vblank_start=1; otherwise SHALL remain in IDLE.
REQ-019 RD_X -> RD_Y -> RD_M -> CAP_M -> COMMIT -> IDLE unconditionally, one cycle each.
REQ-020 addr SHALL be combinational from state: RD_X BASE_ADDR, RD_Y BASE_ADDR+1, RD_M BASE_ADDR+2, all other states BASE_ADDR.
REQ-021 SHALL capture data_in into shadow X in RD_Y, shadow Y in RD_M, and shadow frame in CAP_M.
REQ-022 Shadow frame data_in > 3 SHALL be replaced by 0 and SHALL raise frame_err for one cycle during COMMIT.
REQ-023 In COMMIT, shadow registers SHALL be copied to sprite_x/sprite_y/sprite_frame; outputs and attr_updated=1 SHALL be visible the cycle after COMMIT, i.e. 6 cycles after the vblank_start cycle.
REQ-024 vblank_start arriving in any state other than IDLE SHALL be ignored; no queuing.
REQ-025 Committed attributes SHALL change only at commit, never mid-frame; shadow values SHALL NOT affect hit testing.
REQ-026 Hit test SHALL use committed values: hit = (hcount >= sprite_x) AND (hcount < sprite_x+SPRITE_W) AND same for vcount/sprite_y/SPRITE_H.
REQ-027 Comparisons SHALL be unsigned in DATA_WIDTH+1 bits so sprite_x+SPRITE_W does not wrap; hcount zero-extended.
REQ-028 col = (hcount - sprite_x) low 4 bits, row = (vcount - sprite_y) low 4 bits; glyph_addr SHALL be 0 when hit=0.
REQ-029 sprite_hit and glyph_addr SHALL lag hcount/vcount by exactly 1 cycle.
REQ-030 Sprite partially off-screen (sprite_x > 639) SHALL simply produce no hits; no clipping logic.

Reset
REQ-031 reset SHALL force state IDLE and zero shadow registers, sprite_x, sprite_y, sprite_frame, attr_updated, frame_err, sprite_hit, glyph_addr.
REQ-032 reset during any fetch state SHALL abort it with no commit; the next vblank_start after reset release SHALL start a full fetch.
REQ-033 reset SHALL take priority over vblank_start in the same cycle.

Structure
REQ-034 Shared package SHALL hold sprite attribute addresses (X 'h1000, Y 'h1001, frame 'h1002), frame encodings 0-3, and SPRITE_W/SPRITE_H defaults, also used by the movement stage.
REQ-035 The hit test and glyph address pipeline SHALL be a sub-module sprite_hit_test; FSM and attribute registers stay in the top.

Verification
REQ-036 Memory X=100,Y=200,frame=2; pulse vblank_start at cycle 0 -> addr 'h1000,'h1001,'h1002 at cycles 1-3; attr_updated=1 and sprite_x=100,sprite_y=200,sprite_frame=2 at cycle 6.
REQ-037 Committed X=100,Y=200,frame=1; hcount=105,vcount=203 -> next cycle sprite_hit=1, glyph_addr={2'd1,4'd3,4'd5}; hcount=116 -> sprite_hit=0, glyph_addr=0.
REQ-038 Frame word=7 -> frame_err pulse at COMMIT, sprite_frame=0 afterwards.
REQ-039 Second vblank_start at cycle 2 of a fetch -> ignored, single attr_updated pulse.
REQ-040 reset asserted in RD_M with prior committed X=50 -> all outputs 0, no attr_updated; next vblank_start performs full 6-cycle fetch.
REQ-041 sprite_x='hFFF8 -> no wrap; sprite_hit=0 for hcount 0..639.

Source files
------------

// File: rtl/sprite_attr_fetch_pkg.sv
// Shared sprite definitions: attribute word addresses, animation frame
// encodings, default sprite size and the attribute fetch FSM states.
package sprite_attr_fetch_pkg;

  localparam logic [15:0] SPRITE_X_ADDR     = 16'h1000;
  localparam logic [15:0] SPRITE_Y_ADDR     = 16'h1001;
  localparam logic [15:0] SPRITE_FRAME_ADDR = 16'h1002;

  localparam logic [1:0] FRAME_STAND      = 2'd0;
  localparam logic [1:0] FRAME_WALK_START = 2'd1;
  localparam logic [1:0] FRAME_WALK_MID   = 2'd2;
  localparam logic [1:0] FRAME_WALK_END   = 2'd3;

  localparam int SPRITE_W_DEFAULT = 16;
  localparam int SPRITE_H_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_X   = 3'd1,
    RD_Y   = 3'd2,
    RD_M   = 3'd3,
    CAP_M  = 3'd4,
    COMMIT = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/sprite_attr_fetch_hit.sv
// sprite_hit_test: registered pixel-in-sprite test and glyph ROM address.
// Compares are done one bit wider than the attributes so x+W never wraps.
module sprite_hit_test
  import sprite_attr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SPRITE_W   = SPRITE_W_DEFAULT,
  parameter int SPRITE_H   = SPRITE_H_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic [DATA_WIDTH-1:0] sprite_x,
  input  logic [DATA_WIDTH-1:0] sprite_y,
  input  logic [1:0]            sprite_frame,
  output logic                  sprite_hit,
  output logic [9:0]            glyph_addr
);

  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0] h_ext_p0;
  logic [EW-1:0] v_ext_p0;
  logic [EW-1:0] x_ext_p0;
  logic [EW-1:0] y_ext_p0;
  logic          hit_p0;
  logic [3:0]    col_p0;
  logic [3:0]    row_p0;

  // Stage p0: combinational box test on the committed attributes
  always_comb begin
    h_ext_p0 = EW'(hcount);
    v_ext_p0 = EW'(vcount);
    x_ext_p0 = EW'(sprite_x);
    y_ext_p0 = EW'(sprite_y);
    hit_p0   = (h_ext_p0 >= x_ext_p0) && (h_ext_p0 < x_ext_p0 + EW'(SPRITE_W)) &&
               (v_ext_p0 >= y_ext_p0) && (v_ext_p0 < y_ext_p0 + EW'(SPRITE_H));
    col_p0   = hcount[3:0] - sprite_x[3:0];
    row_p0   = vcount[3:0] - sprite_y[3:0];
  end

  // Stage p1: register hit and glyph address, glyph forced to 0 off-sprite
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      glyph_addr <= '0;
    end else begin
      sprite_hit <= hit_p0;
      glyph_addr <= hit_p0 ? {sprite_frame, row_p0, col_p0} : 10'd0;
    end
  end

endmodule

// File: rtl/sprite_attr_fetch.sv
// sprite_attr_fetch: on each vblank, reads X, Y and frame words from shared
// memory into shadow registers, then commits them atomically so the sprite
// never changes mid-frame. Hit testing runs on committed values only.
module sprite_attr_fetch
  import sprite_attr_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(SPRITE_X_ADDR),
  parameter int                    SPRITE_W   = SPRITE_W_DEFAULT,
  parameter int                    SPRITE_H   = SPRITE_H_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  output logic [DATA_WIDTH-1:0] sprite_x,
  output logic [DATA_WIDTH-1:0] sprite_y,
  output logic [1:0]            sprite_frame,
  output logic                  attr_updated,
  output logic                  frame_err,
  output logic                  sprite_hit,
  output logic [9:0]            glyph_addr
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] shadow_x;
  logic [DATA_WIDTH-1:0] shadow_y;
  logic [1:0]            shadow_frame;
  logic                  frame_ok;

  assign frame_ok = (data_in <= DATA_WIDTH'(FRAME_WALK_END));

  // Read address follows the state; memory data returns one cycle later
  always_comb begin
    case (state)
      RD_X:    addr = BASE_ADDR;
      RD_Y:    addr = BASE_ADDR + ADDR_WIDTH'(1);
      RD_M:    addr = BASE_ADDR + ADDR_WIDTH'(2);
      default: addr = BASE_ADDR;
    endcase
  end

  // Fetch sequencer: capture into shadows, then commit all attributes at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_frame <= FRAME_STAND;
      sprite_x     <= '0;
      sprite_y     <= '0;
      sprite_frame <= FRAME_STAND;
      attr_updated <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      attr_updated <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE:   if (vblank_start) state <= RD_X;
        RD_X:   state <= RD_Y;
        RD_Y: begin
          shadow_x <= data_in;
          state    <= RD_M;
        end
        RD_M: begin
          shadow_y <= data_in;
          state    <= CAP_M;
        end
        CAP_M: begin
          // Out-of-range frame falls back to standing; error shows during COMMIT
          shadow_frame <= frame_ok ? data_in[1:0] : FRAME_STAND;
          frame_err    <= ~frame_ok;
          state        <= COMMIT;
        end
        COMMIT: begin
          sprite_x     <= shadow_x;
          sprite_y     <= shadow_y;
          sprite_frame <= shadow_frame;
          attr_updated <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sprite_hit_test #(
    .DATA_WIDTH (DATA_WIDTH),
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H)
  ) u_hit (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_frame (sprite_frame),
    .sprite_hit   (sprite_hit),
    .glyph_addr   (glyph_addr)
  );

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Testbench for sprite_attr_fetch: directed fetch sequences, a vector table
// for the hit test and randomized fetch/hit runs against a simple model.
module tb_sprite_attr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank_start;
  logic [15:0] data_in;
  logic [15:0] addr;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] sprite_x;
  logic [15:0] sprite_y;
  logic [1:0]  sprite_frame;
  logic        attr_updated;
  logic        frame_err;
  logic        sprite_hit;
  logic [9:0]  glyph_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // Shared memory contents seen by the fetch
  logic [15:0] mem_x, mem_y, mem_f;

  // Reference model of the committed attributes
  int m_x, m_y, m_f;

  typedef struct {
    int          h;
    int          v;
    logic        hit;
    logic [9:0]  glyph;
  } hit_vec_t;

  hit_vec_t vecs [8];

  sprite_attr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .vblank_start (vblank_start),
    .data_in      (data_in),
    .addr         (addr),
    .hcount       (hcount),
    .vcount       (vcount),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_frame (sprite_frame),
    .attr_updated (attr_updated),
    .frame_err    (frame_err),
    .sprite_hit   (sprite_hit),
    .glyph_addr   (glyph_addr)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle read latency
  always @(posedge clk) begin
    case (addr)
      16'h1000: data_in <= mem_x;
      16'h1001: data_in <= mem_y;
      16'h1002: data_in <= mem_f;
      default:  data_in <= 16'hDEAD;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Pulse vblank and advance to cycle 6 (commit visible); model commits too
  task automatic fetch_and_check(input string tag);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    repeat (5) step();
    m_x = int'(mem_x);
    m_y = int'(mem_y);
    m_f = (int'(mem_f) > 3) ? 0 : int'(mem_f);
    check({tag, " attr_updated"}, int'(attr_updated), 1);
    check({tag, " sprite_x"}, int'(sprite_x), m_x);
    check({tag, " sprite_y"}, int'(sprite_y), m_y);
    check({tag, " sprite_frame"}, int'(sprite_frame), m_f);
  endtask

  function automatic int model_hit(input int h, input int v);
    return (h >= m_x && h < m_x + 16 && v >= m_y && v < m_y + 16) ? 1 : 0;
  endfunction

  function automatic int model_glyph(input int h, input int v);
    if (model_hit(h, v) == 0) return 0;
    return m_f * 256 + ((v - m_y) % 16) * 16 + ((h - m_x) % 16);
  endfunction

  initial begin
    int pulses;
    int hits;

    vecs[0] = '{105, 203, 1'b1, {2'd1, 4'd3, 4'd5}};
    vecs[1] = '{116, 203, 1'b0, 10'd0};
    vecs[2] = '{100, 200, 1'b1, {2'd1, 4'd0, 4'd0}};
    vecs[3] = '{115, 215, 1'b1, {2'd1, 4'd15, 4'd15}};
    vecs[4] = '{99,  200, 1'b0, 10'd0};
    vecs[5] = '{100, 216, 1'b0, 10'd0};
    vecs[6] = '{100, 199, 1'b0, 10'd0};
    vecs[7] = '{108, 207, 1'b1, {2'd1, 4'd7, 4'd8}};

    reset = 1'b1;
    vblank_start = 1'b0;
    hcount = 10'd0;
    vcount = 10'd0;
    mem_x = 16'd0; mem_y = 16'd0; mem_f = 16'd0;
    m_x = 0; m_y = 0; m_f = 0;
    repeat (3) step();

    // Reset state
    check("rst sprite_x", int'(sprite_x), 0);
    check("rst sprite_y", int'(sprite_y), 0);
    check("rst sprite_frame", int'(sprite_frame), 0);
    check("rst attr_updated", int'(attr_updated), 0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst sprite_hit", int'(sprite_hit), 0);
    check("rst glyph_addr", int'(glyph_addr), 0);
    check("rst addr", int'(addr), 'h1000);
    reset = 1'b0;
    step();

    // Basic fetch with cycle-accurate address and commit timing
    mem_x = 16'd100; mem_y = 16'd200; mem_f = 16'd2;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    check("c1 addr", int'(addr), 'h1000);
    step();
    check("c2 addr", int'(addr), 'h1001);
    step();
    check("c3 addr", int'(addr), 'h1002);
    step();
    check("c4 addr", int'(addr), 'h1000);
    step();
    check("c5 attr_updated", int'(attr_updated), 0);
    check("c5 sprite_x unchanged", int'(sprite_x), 0);
    check("c5 frame_err", int'(frame_err), 0);
    step();
    check("c6 attr_updated", int'(attr_updated), 1);
    check("c6 sprite_x", int'(sprite_x), 100);
    check("c6 sprite_y", int'(sprite_y), 200);
    check("c6 sprite_frame", int'(sprite_frame), 2);
    step();
    check("c7 attr_updated", int'(attr_updated), 0);

    // Out-of-range frame word
    mem_f = 16'd7;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    repeat (4) step();
    check("ferr c5 frame_err", int'(frame_err), 1);
    step();
    check("ferr c6 frame_err", int'(frame_err), 0);
    check("ferr c6 attr_updated", int'(attr_updated), 1);
    check("ferr sprite_frame", int'(sprite_frame), 0);
    m_f = 0;

    // Second vblank during a fetch is ignored
    mem_f = 16'd3;
    pulses = 0;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (attr_updated) pulses++;
      step();
    end
    check("double vblank pulses", pulses, 1);
    check("double vblank frame", int'(sprite_frame), 3);

    // Reset in RD_M aborts fetch, then a full fetch follows
    mem_x = 16'd50; mem_y = 16'd60; mem_f = 16'd1;
    fetch_and_check("pre-abort");
    step();
    mem_x = 16'd77; mem_y = 16'd88; mem_f = 16'd2;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    step();
    step();
    check("abort in RD_M addr", int'(addr), 'h1002);
    reset = 1'b1;
    vblank_start = 1'b1;
    step();
    reset = 1'b0;
    vblank_start = 1'b0;
    check("abort sprite_x", int'(sprite_x), 0);
    check("abort sprite_y", int'(sprite_y), 0);
    check("abort sprite_frame", int'(sprite_frame), 0);
    check("abort addr idle", int'(addr), 'h1000);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (attr_updated) pulses++;
      step();
    end
    check("abort no commit", pulses, 0);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    repeat (4) step();
    check("refetch c5 attr_updated", int'(attr_updated), 0);
    step();
    m_x = 77; m_y = 88; m_f = 2;
    check("refetch c6 attr_updated", int'(attr_updated), 1);
    check("refetch sprite_x", int'(sprite_x), 77);
    check("refetch sprite_y", int'(sprite_y), 88);

    // Hit test vector table
    mem_x = 16'd100; mem_y = 16'd200; mem_f = 16'd1;
    fetch_and_check("table setup");
    for (int i = 0; i < 8; i++) begin
      hcount = 10'(vecs[i].h);
      vcount = 10'(vecs[i].v);
      step();
      check($sformatf("vec%0d sprite_hit", i), int'(sprite_hit), int'(vecs[i].hit));
      check($sformatf("vec%0d glyph_addr", i), int'(glyph_addr), int'(vecs[i].glyph));
    end

    // Large X must not wrap into visible range
    mem_x = 16'hFFF8; mem_y = 16'd0; mem_f = 16'd0;
    fetch_and_check("wrap setup");
    hits = 0;
    vcount = 10'd4;
    for (int h = 0; h < 640; h++) begin
      hcount = 10'(h);
      step();
      if (sprite_hit) hits++;
    end
    check("no wrap hits", hits, 0);

    // Sprite at right edge: exactly ten visible columns
    mem_x = 16'd630; mem_y = 16'd10;
    fetch_and_check("edge setup");
    hits = 0;
    vcount = 10'd12;
    for (int h = 600; h < 640; h++) begin
      hcount = 10'(h);
      step();
      if (sprite_hit) hits++;
    end
    check("edge hits", hits, 10);

    // Randomized fetches and pixel probes
    for (int r = 0; r < 10; r++) begin
      mem_x = 16'($urandom_range(0, 1000));
      mem_y = 16'($urandom_range(0, 600));
      mem_f = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(4, 65535)) : 16'($urandom_range(0, 3));
      fetch_and_check($sformatf("rand%0d", r));
      for (int k = 0; k < 40; k++) begin
        int h, v;
        h = m_x + int'($urandom_range(0, 40)) - 12;
        v = m_y + int'($urandom_range(0, 40)) - 12;
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        hcount = 10'(h);
        vcount = 10'(v);
        step();
        check($sformatf("rand%0d hit h=%0d v=%0d", r, h, v), int'(sprite_hit), model_hit(h, v));
        check($sformatf("rand%0d glyph h=%0d v=%0d", r, h, v), int'(glyph_addr), model_glyph(h, v));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
